// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and RISC-V opcode constants, also used by the
// immediate generator and decoder.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_LUI    = 7'h37;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational slicer of a 32-bit RV instruction into its fixed-position
// register/opcode fields; shared with the decoder.
module instr_field_split (
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7
);

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the RV64 multicycle core: fetch PC, imem handshake and IR.
// Optional misaligned-fetch trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_load,
    output logic            instr_valid,
    output logic            busy,
    output logic            fault
);

    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    fetch_state_t    state_r;
    logic [XLEN-1:0] fpc_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_plus4_r;
    logic [XLEN-1:0] imem_addr_r;
    logic [31:0]     ir_r;
    logic            kill_r;
    logic            instr_valid_r;
    logic            instr_load_r;
    logic            imem_req_r;
    logic            busy_r;
    logic            fault_r;

    logic [XLEN-1:0] redirect_addr_s;
    logic [XLEN-1:0] start_addr_s;
    logic            start_s;
    logic            misalign_s;
    logic            load_s;

    // Next-fetch address selection and IR write qualification
    always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect_addr_s = redirect_pc;
`else
        redirect_addr_s = redirect_pc & ALIGN_MASK;
`endif
        // A redirect in the same cycle as the request bypasses the fpc register
        start_addr_s = redirect_valid ? redirect_addr_s : fpc_r;
        start_s      = (state_r == IDLE) && fetch_req && !stall;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_s   = is_misaligned(start_addr_s[1:0]);
`else
        misalign_s   = 1'b0;
`endif
        // A redirect coinciding with the response makes that word wrong-path
        load_s       = (state_r == WAIT) && imem_rvalid && !kill_r && !redirect_valid;
    end

    // Fetch FSM, fetch PC, IR and all registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            fpc_r         <= RESET_PC;
            pc_r          <= RESET_PC;
            pc_plus4_r    <= RESET_PC + PC_STEP;
            imem_addr_r   <= RESET_PC;
            ir_r          <= NOP_INSTR;
            kill_r        <= 1'b0;
            instr_valid_r <= 1'b0;
            instr_load_r  <= 1'b0;
            imem_req_r    <= 1'b0;
            busy_r        <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            instr_load_r <= load_s;
            fault_r      <= start_s && misalign_s;

            if (redirect_valid) begin
                fpc_r <= redirect_addr_s;
            end else if (load_s) begin
                fpc_r <= fpc_r + PC_STEP;
            end

            if (load_s) begin
                ir_r          <= imem_rdata;
                pc_r          <= fpc_r;
                pc_plus4_r    <= fpc_r + PC_STEP;
                instr_valid_r <= 1'b1;
            end else if ((state_r == IDLE) && redirect_valid) begin
                instr_valid_r <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (start_s && !misalign_s) begin
                        state_r     <= REQ;
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= start_addr_s;
                        busy_r      <= 1'b1;
                    end
                end
                REQ: begin
                    // Address stays put: the request completes even if redirected
                    if (redirect_valid) begin
                        kill_r <= 1'b1;
                    end
                    if (imem_ready) begin
                        state_r    <= WAIT;
                        imem_req_r <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_r <= IDLE;
                        kill_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (redirect_valid) begin
                        kill_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    imem_req_r <= 1'b0;
                    kill_r     <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = imem_addr_r;
    assign instr       = ir_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_r;
    assign instr_load  = instr_load_r;
    assign instr_valid = instr_valid_r;
    assign busy        = busy_r;
    assign fault       = fault_r;

    instr_field_split u_field_split (
        .instr  (ir_r),
        .opcode (opcode),
        .rd     (rd),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct7 (funct7)
    );

endmodule
